// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU busy lengths and controller states shared by the ALU command controller.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    localparam int MUL_BUSY_CYC = 5;
    localparam int DIV_BUSY_CYC = 9;

    typedef enum logic [2:0] {
        ST_OFF, ST_PWR_UP, ST_READY, ST_ISSUE, ST_WAIT, ST_RESP, ST_PWR_DN
    } ctrl_state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                          OP_NOT, OP_SHL, OP_SHR, OP_MUL, OP_DIV};
    endfunction
endpackage

// File: rtl/alu_pwr_seq.sv
// alu_pwr_seq: power-up/power-down sequencing, pwr_en/iso_en generation, power-up and idle counters.
module alu_pwr_seq
    import alu_pkg::*;
#(
    parameter int PWR_UP_CYC   = 4,
    parameter int IDLE_OFF_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  ctrl_state_t i_state,
    input  logic        i_accept,
    output logic        o_pwr_en,
    output logic        o_iso_en,
    output logic        o_power_good,
    output logic        o_off_req,
    output logic        o_powered
);
    logic [3:0] r_up_cnt;
    logic [7:0] r_idle_cnt;
    logic       r_pwr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up_cnt   <= '0;
            r_idle_cnt <= '0;
            r_pwr      <= 1'b0;
        end else begin
            r_up_cnt   <= (i_state == ST_PWR_UP) ? r_up_cnt + 4'd1 : 4'd0;
            r_idle_cnt <= (i_state == ST_READY && !i_accept) ? r_idle_cnt + 8'd1 : 8'd0;
            r_pwr      <= (i_state == ST_PWR_UP) | (r_pwr & (i_state != ST_PWR_DN));
        end
    end

    assign o_power_good = (i_state == ST_PWR_UP) && (r_up_cnt == 4'(PWR_UP_CYC - 1));
    assign o_off_req    = (i_state == ST_READY) && (r_idle_cnt == 8'(IDLE_OFF_CYC - 1));
    assign o_pwr_en     = r_pwr | (i_state == ST_PWR_UP);
    // Isolation only lifts once the domain is fully up; PWR_DN re-isolates before r_pwr drops.
    assign o_iso_en     = !(r_pwr && (i_state inside {ST_READY, ST_ISSUE, ST_WAIT, ST_RESP}));
    assign o_powered    = r_pwr;
endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command initiator and power manager for the gated ALU datapath.
// Define ALU_TIMEOUT_EN to build the busy watchdog that aborts a stuck ALU operation.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int PWR_UP_CYC   = 4,
    parameter int IDLE_OFF_CYC = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        alu_pwr_en,
    output logic        iso_en,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    output logic        alu_start,
    input  logic [15:0] alu_result,
    input  logic        alu_busy
);
`ifdef ALU_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    ctrl_state_t r_state, w_next;
    logic [15:0] r_alu_a, r_alu_b, r_rsp_result;
    logic [3:0]  r_alu_opcode;
    logic [7:0]  r_busy_cnt;
    logic        r_rsp_err, r_kill;
    logic        w_accept, w_legal, w_power_good, w_off_req, w_powered, w_timeout, w_done;

    assign cmd_ready  = (r_state == ST_OFF) || (r_state == ST_READY);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_legal    = op_legal(cmd_opcode);
    assign w_timeout  = TIMEOUT_EN && (r_state == ST_WAIT) && alu_busy
                        && (r_busy_cnt == 8'(BUSY_TIMEOUT - 1));
    assign w_done     = (r_state == ST_WAIT) && (!alu_busy || w_timeout);
    assign rsp_valid  = (r_state == ST_RESP);
    assign alu_start  = (r_state == ST_ISSUE);
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_opcode = r_alu_opcode;

    alu_pwr_seq #(.PWR_UP_CYC(PWR_UP_CYC), .IDLE_OFF_CYC(IDLE_OFF_CYC)) u_pwr_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_state      (r_state),
        .i_accept     (w_accept),
        .o_pwr_en     (alu_pwr_en),
        .o_iso_en     (iso_en),
        .o_power_good (w_power_good),
        .o_off_req    (w_off_req),
        .o_powered    (w_powered)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_OFF:    if (w_accept) w_next = w_legal ? ST_PWR_UP : ST_RESP;
            ST_PWR_UP: if (w_power_good) w_next = ST_ISSUE;
            ST_READY:  w_next = w_accept ? (w_legal ? ST_ISSUE : ST_RESP)
                              : w_off_req ? ST_PWR_DN : ST_READY;
            ST_ISSUE:  w_next = ST_WAIT;
            ST_WAIT:   if (w_done) w_next = ST_RESP;
            ST_RESP:   if (rsp_ready) w_next = r_kill ? ST_PWR_DN : w_powered ? ST_READY : ST_OFF;
            ST_PWR_DN: w_next = ST_OFF;
            default:   w_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_OFF;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_opcode <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_busy_cnt   <= '0;
            r_kill       <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy_cnt <= (r_state == ST_WAIT && alu_busy) ? r_busy_cnt + 8'd1 : 8'd0;
            // A watchdog abort must power-cycle the ALU after its error response.
            r_kill     <= w_timeout | (r_kill && r_state != ST_PWR_DN);
            if (w_accept) begin
                r_alu_a      <= cmd_a;
                r_alu_b      <= cmd_b;
                r_alu_opcode <= cmd_opcode;
            end
            if (w_accept && !w_legal) begin
                r_rsp_result <= '0;
                r_rsp_err    <= 1'b1;
            end else if (w_done) begin
                r_rsp_result <= w_timeout ? 16'd0 : alu_result;
                r_rsp_err    <= w_timeout;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: randomized command stream against a cycle-latency and power-state reference model.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    localparam int PWR_UP_CYC   = 4;
    localparam int IDLE_OFF_CYC = 16;
    localparam int BUSY_TIMEOUT = 15;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [3:0]  cmd_opcode = '0, alu_opcode;
    logic [15:0] cmd_a = '0, cmd_b = '0, rsp_result, alu_a, alu_b, alu_result, r_res;
    logic        alu_pwr_en, iso_en, alu_start, alu_busy, stuck = 1'b0;
    int          rem, cyc = 0, n_tests = 0, n_fail = 0, th = 0;
    logic        m_pwr = 1'b0;

    alu_cmd_ctrl #(.PWR_UP_CYC(PWR_UP_CYC), .IDLE_OFF_CYC(IDLE_OFF_CYC), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_start(alu_start), .alu_result(alu_result), .alu_busy(alu_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~a;
            4'd6: return a << b[3:0];
            4'd7: return a >> b[3:0];
            4'd8: return p[15:0];
            4'd9: return (b == 16'd0) ? 16'd0 : a / b;
            default: return 16'd0;
        endcase
    endfunction

    // Behavioural ALU: shows garbage while busy so an early capture is visible.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= 0;
            r_res <= '0;
        end else if (!alu_pwr_en) begin
            rem <= 0;
        end else if (alu_start) begin
            rem   <= (alu_opcode == 4'd8) ? MUL_BUSY_CYC : (alu_opcode == 4'd9) ? DIV_BUSY_CYC : 0;
            r_res <= alu_fn(alu_opcode, alu_a, alu_b);
        end else if (rem > 0) begin
            rem <= rem - 1;
        end
    end
    assign alu_busy   = stuck || (rem != 0);
    assign alu_result = alu_busy ? 16'hDEAD : r_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(output int ta);
        int k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        check("cmd_ready_wait", 32'(k < 50), 32'd1);
        ta = cyc;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input int gap, input int hold, output logic [15:0] got);
        int k, ta, t_start, n_start, exp_lat;
        logic pwr_exp, legal;
        logic [15:0] res;
        legal = (op <= 4'd9);
        repeat (gap) @(negedge clk);
        wait_ready(ta);
        pwr_exp = m_pwr && (ta - th) <= IDLE_OFF_CYC;
        check("pwr_en_at_accept", 32'(alu_pwr_en), 32'(pwr_exp));
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_opcode = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        k = 0; n_start = 0; t_start = -1;
        while (!rsp_valid && k < 60) begin
            if (alu_start) begin
                n_start++;
                if (t_start < 0) t_start = cyc;
                check("iso_at_start", 32'(iso_en), 32'd0);
            end
            @(negedge clk); k++;
        end
        exp_lat = !legal ? 1 : (pwr_exp ? 0 : PWR_UP_CYC) + ((op == 4'd8) ? 8 : (op == 4'd9) ? 12 : 3);
        check("rsp_latency", 32'(cyc - ta), 32'(exp_lat));
        check("start_count", 32'(n_start), 32'(legal));
        if (legal) check("start_cycle", 32'(t_start - ta), 32'(pwr_exp ? 1 : PWR_UP_CYC + 1));
        else check("pwr_en_illegal", 32'(alu_pwr_en), 32'(pwr_exp));
        res = legal ? alu_fn(op, a, b) : 16'd0;
        check("rsp_result", 32'(rsp_result), 32'(res));
        check("rsp_err", 32'(rsp_err), 32'(!legal));
        check("alu_op_held", {alu_opcode, alu_a, alu_b}, {op, a, b});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_result", 32'(rsp_result), 32'(res));
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        got = rsp_result;
        rsp_ready = 1'b1;
        th = cyc;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_single", 32'(rsp_valid), 32'd0);
        m_pwr = pwr_exp || legal;
    endtask

    initial begin
        logic [15:0] got;
        int k, ta, tdn, seen;
        logic [3:0] op;
        @(negedge clk);
        check("rst_pwr_iso", {alu_pwr_en, iso_en, alu_start}, 3'b010);
        check("rst_alu_regs", {alu_opcode, alu_a, alu_b}, 36'd0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_result}, 18'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(4'd0, 16'h1234, 16'h0101, 0, 0, got);
        check("tp1_add", 32'(got), 32'h1335);
        run_cmd(4'd8, 16'h0012, 16'h0034, 0, 0, got);
        check("tp2_mul", 32'(got), 32'h03A8);
        run_cmd(4'd9, 16'd100, 16'd7, 1, 0, got);
        check("tp3_div", 32'(got), 32'h000E);
        run_cmd(4'd9, 16'd5, 16'd0, 0, 0, got);
        check("tp3_div0", 32'(got), 32'h0000);
        run_cmd(4'd1, 16'h0003, 16'h0005, 2, 10, got);
        check("tp5_sub", 32'(got), 32'hFFFE);

        // Idle power-down: isolation one cycle before power drops.
        k = 0;
        while (!(iso_en && alu_pwr_en) && k < 40) begin @(negedge clk); k++; end
        tdn = cyc;
        check("pdn_cycle", 32'(tdn - th), 32'(IDLE_OFF_CYC + 1));
        @(negedge clk);
        check("pdn_off", {alu_pwr_en, iso_en}, 2'b01);
        m_pwr = 1'b0;

        run_cmd(4'hA, 16'h1111, 16'h2222, 0, 0, got);
        check("tp4_illegal_result", 32'(got), 32'd0);

        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            run_cmd(op, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 5),
                    $urandom_range(0, 3), got);
        end

        // Reset in the middle of a DIV: nothing comes back and the domain drops.
        run_cmd(4'd0, 16'd1, 16'd2, 0, 0, got);
        wait_ready(ta);
        cmd_valid = 1'b1; cmd_opcode = 4'd9; cmd_a = 16'd50; cmd_b = 16'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pwr", {alu_pwr_en, iso_en, rsp_valid, alu_start}, 4'b0100);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin @(negedge clk); seen += int'(rsp_valid); end
        check("midrst_no_rsp", 32'(seen), 32'd0);
        m_pwr = 1'b0;

`ifdef ALU_TIMEOUT_EN
        run_cmd(4'd2, 16'hF0F0, 16'h0FF0, 0, 0, got);
        stuck = 1'b1;
        wait_ready(ta);
        cmd_valid = 1'b1; cmd_opcode = 4'd8; cmd_a = 16'd3; cmd_b = 16'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 60) begin @(negedge clk); k++; end
        check("to_latency", 32'(cyc - ta), 32'(2 + BUSY_TIMEOUT));
        check("to_rsp", {rsp_err, rsp_result}, 17'h10000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        stuck = 1'b0;
        check("to_pwr_dn", {alu_pwr_en, iso_en, rsp_valid}, 3'b110);
        @(negedge clk);
        check("to_off", {alu_pwr_en, iso_en, cmd_ready}, 3'b011);
        m_pwr = 1'b0;
        run_cmd(4'd3, 16'h00F0, 16'h000F, 0, 0, got);
        check("to_recover", 32'(got), 32'h00FF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
